// File: rtl/ddr_rx_pkg.sv
// Shared constants for the HDR-DDR receive path.
// Holds the rx mode codes (also used by rx and the engine FSM), the sequencer
// state encoding and the transfer error codes.
package ddr_rx_pkg;

    localparam int unsigned MODE_W  = 4;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ERR_W   = 3;

    // rx mode codes
    localparam logic [MODE_W-1:0] MODE_PREAMBLE    = 4'd0;
    localparam logic [MODE_W-1:0] MODE_DESER_BYTE  = 4'd3;
    localparam logic [MODE_W-1:0] MODE_CHECK_TOKEN = 4'd4;
    localparam logic [MODE_W-1:0] MODE_CHECK_PAR   = 4'd5;
    localparam logic [MODE_W-1:0] MODE_CHECK_CRC   = 4'd6;
    localparam logic [MODE_W-1:0] MODE_ERROR       = 4'd7;
    localparam logic [MODE_W-1:0] MODE_IDLE        = 4'd15;

    // transfer error codes
    localparam logic [ERR_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [ERR_W-1:0] ERR_PREAMBLE = 3'd1;
    localparam logic [ERR_W-1:0] ERR_PARITY   = 3'd2;
    localparam logic [ERR_W-1:0] ERR_TOKEN    = 3'd3;
    localparam logic [ERR_W-1:0] ERR_CRC      = 3'd4;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 3'd5;
    localparam logic [ERR_W-1:0] ERR_OVERRUN  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_PRE_1    = 4'd1,
        ST_PRE_0    = 4'd2,
        ST_BYTE_MSB = 4'd3,
        ST_BYTE_LSB = 4'd4,
        ST_PARITY   = 4'd5,
        ST_TOKEN    = 4'd6,
        ST_CRC      = 4'd7,
        ST_ERR      = 4'd8,
        ST_DONE     = 4'd9
    } state_e;

endpackage

// File: rtl/ddr_rx_watchdog.sv
// Per-mode watchdog: clear/enable counter that pulses expire for one cycle
// once TIMEOUT_CYCLES enabled cycles have elapsed since the last clear.
// Ports: i_sys_clk, i_sys_rst (async, active-high), clr (restart count),
//        en (count this cycle), expire (one-cycle timeout pulse).
module ddr_rx_watchdog #(
    parameter int unsigned TIMEOUT_W      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] cnt;

    // Counter parks at the limit so expire fires only once per clear
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            expire <= en && (cnt == CNT_LAST);
            if (en && (cnt != CNT_LIMIT)) begin
                cnt <= cnt + TIMEOUT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_rx_sequencer.sv
// Sequences the HDR-DDR rx datapath through its modes for one read transfer:
// preamble pairs, data words (MSB, LSB, parity) and the closing token/CRC.
// Counts data words, latches the first error and drives rx into ERROR mode.
// Ports: i_sys_clk/i_sys_rst; engine start/abort/word_count in, done/error/
//        error_code out; rx mode_done/pre/error in, rx_en/rx_mode out;
//        o_busy and o_word_cnt status.
module ddr_rx_sequencer
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WORD_CNT_W     = 8,
    parameter int unsigned TIMEOUT_W      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_engine_start,
    input  logic                  i_engine_abort,
    input  logic [WORD_CNT_W-1:0] i_engine_word_count,
    input  logic                  i_rx_mode_done,
    input  logic                  i_rx_pre,
    input  logic                  i_rx_error,
    output logic                  o_rx_en,
    output logic [MODE_W-1:0]     o_rx_mode,
    output logic                  o_busy,
    output logic [WORD_CNT_W-1:0] o_word_cnt,
    output logic                  o_engine_done,
    output logic                  o_engine_error,
    output logic [ERR_W-1:0]      o_engine_error_code
);

    state_e                state, state_d;
    logic                  p1, p1_d;
    logic                  blank;
    logic                  done_ok;
    logic                  expire;
    logic                  err_hit;
    logic [ERR_W-1:0]      err_new;
    logic [WORD_CNT_W-1:0] word_cnt_d;
    logic [ERR_W-1:0]      code_d;
    logic                  rx_en_d, busy_d, done_d, error_d;
    logic [MODE_W-1:0]     mode_d;

    // Watchdog restarts on every state change
    ddr_rx_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .clr       (state_d != state),
        .en        (o_rx_en),
        .expire    (expire)
    );

    // State register plus transfer bookkeeping
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state               <= ST_IDLE;
            p1                  <= 1'b0;
            blank               <= 1'b0;
            o_word_cnt          <= '0;
            o_engine_error_code <= ERR_NONE;
        end else begin
            state               <= state_d;
            p1                  <= p1_d;
            blank               <= (state_d != state);
            o_word_cnt          <= word_cnt_d;
            o_engine_error_code <= code_d;
        end
    end

    // Next state; rx still shows the previous mode's done in the first
    // cycle of each state, so done is blanked then
    always_comb begin
        state_d    = state;
        p1_d       = p1;
        word_cnt_d = o_word_cnt;
        code_d     = o_engine_error_code;
        err_hit    = 1'b0;
        err_new    = ERR_NONE;
        done_ok    = i_rx_mode_done && !blank;

        if (i_engine_abort) begin
            state_d = ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (i_engine_start) begin
                state_d    = ST_PRE_1;
                word_cnt_d = '0;
                code_d     = ERR_NONE;
            end
        end else if (state == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (done_ok) begin
            case (state)
                ST_PRE_1: begin
                    p1_d    = i_rx_pre;
                    state_d = ST_PRE_0;
                end
                ST_PRE_0: begin
                    case ({p1, i_rx_pre})
                        2'b10: begin
                            if (o_word_cnt < i_engine_word_count) begin
                                state_d = ST_BYTE_MSB;
                            end else begin
                                err_hit = 1'b1;
                                err_new = ERR_OVERRUN;
                            end
                        end
                        2'b01:   state_d = ST_TOKEN;
                        default: begin
                            err_hit = 1'b1;
                            err_new = ERR_PREAMBLE;
                        end
                    endcase
                end
                ST_BYTE_MSB: state_d = ST_BYTE_LSB;
                ST_BYTE_LSB: state_d = ST_PARITY;
                ST_PARITY: begin
                    if (i_rx_error) begin
                        err_hit = 1'b1;
                        err_new = ERR_PARITY;
                    end else begin
                        state_d = ST_PRE_1;
                        if (o_word_cnt != '1) begin
                            word_cnt_d = o_word_cnt + WORD_CNT_W'(1);
                        end
                    end
                end
                ST_TOKEN: begin
                    if (i_rx_error) begin
                        err_hit = 1'b1;
                        err_new = ERR_TOKEN;
                    end else begin
                        state_d = ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (i_rx_error) begin
                        err_hit = 1'b1;
                        err_new = ERR_CRC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_ERR:  state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            if (state == ST_ERR) begin
                state_d = ST_DONE;
                if (o_engine_error_code == ERR_NONE) begin
                    code_d = ERR_TIMEOUT;
                end
            end else begin
                err_hit = 1'b1;
                err_new = ERR_TIMEOUT;
            end
        end

        // Only the first error of a transfer is kept
        if (err_hit) begin
            state_d = ST_ERR;
            if (o_engine_error_code == ERR_NONE) begin
                code_d = err_new;
            end
        end
    end

    // Output decode from the next state, registered below
    always_comb begin
        rx_en_d = 1'b1;
        mode_d  = MODE_IDLE;
        case (state_d)
            ST_PRE_1, ST_PRE_0:       mode_d = MODE_PREAMBLE;
            ST_BYTE_MSB, ST_BYTE_LSB: mode_d = MODE_DESER_BYTE;
            ST_PARITY:                mode_d = MODE_CHECK_PAR;
            ST_TOKEN:                 mode_d = MODE_CHECK_TOKEN;
            ST_CRC:                   mode_d = MODE_CHECK_CRC;
            ST_ERR:                   mode_d = MODE_ERROR;
            default: begin
                rx_en_d = 1'b0;
                mode_d  = MODE_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        error_d = done_d && (code_d != ERR_NONE);
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            o_rx_en        <= 1'b0;
            o_rx_mode      <= MODE_IDLE;
            o_busy         <= 1'b0;
            o_engine_done  <= 1'b0;
            o_engine_error <= 1'b0;
        end else begin
            o_rx_en        <= rx_en_d;
            o_rx_mode      <= mode_d;
            o_busy         <= busy_d;
            o_engine_done  <= done_d;
            o_engine_error <= error_d;
        end
    end

endmodule
